mem_stage: RTL
==============

# mem_stage

Fourth pipeline stage of the LoongArch core. It sits between the execute stage and the writeback stage. It holds one instruction and waits for the data-SRAM response of a load or store issued by execute. It then extracts and sign/zero-extends load data, and forwards the finished `ms_to_ws_bus` and a bypass bus. Writeback flushes are honoured by cancelling any response still in flight.

## Interface
Parameters:
- `DISCARD_W`, default 2: width of the in-flight-response discard counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `ms_allowin`  out  1  stage can accept from execute this cycle
- `es_to_ms_valid`  in  1  execute presents an instruction
- `es_to_ms_bus`  in  `ES_TO_MS_BUS_WD`  writeback fields plus `mem_req`, `load_op[4:0]` (one-hot b/h/w/bu/hu), `addr_lo[1:0]`
- `ws_allowin`  in  1  writeback can accept
- `ms_to_ws_valid`  out  1  instruction handed to writeback
- `ms_to_ws_bus`  out  `MS_TO_WS_BUS_WD`  writeback field layout, `final_result` at [63:32]
- `data_sram_data_ok`  in  1  response strobe, one per issued request, in order
- `data_sram_rdata`  in  32  response data
- `wb_flush`  in  1  writeback exception, ertn, or TLB refetch
- `ms_forward`  out  `MS_FORWARD_WD`  {ms_ex&ms_valid, csr_re, load_pending, rf_we, dest[4:0], result[31:0], ms_valid}

## Operation
- **Capture.** On `es_to_ms_valid & ms_allowin`, register `es_to_ms_bus` and set `ms_valid`. Clear the response buffer.
- **Handshake.**
  - `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
  - `ms_to_ws_valid = ms_valid & ms_ready_go & !wb_flush`.
- **Ready.** `ms_ready_go = !mem_req | ms_ex | buf_valid | (data_ok & discard_cnt==0)`.
- **Response buffer.**
  - An accepted `data_ok` that arrives while `ms_valid & mem_req & !buf_valid` loads `rdata_buf` and sets `buf_valid`.
  - `buf_valid` clears when the instruction leaves.
  - Load data is taken from `rdata_buf` when `buf_valid`, otherwise from `data_sram_rdata`.
- **Load extract.**
  - Byte lane = `addr_lo`; half lane = `addr_lo[1]`.
  - b/h sign-extend; bu/hu zero-extend; w passes through.
  - `final_result = |load_op ? extracted : es_result`.
- **Stores.** Wait for `data_ok` like loads; no result change.
- **Exceptions.** `ms_ex` instructions never wait. Their ex/ecode/esubcode/vaddr fields pass through unchanged.
- **Flush** (`wb_flush`):
  - Clear `ms_valid` at the next edge.
  - If `ms_valid & mem_req & !ms_ex & !buf_valid & !data_ok` holds, increment `discard_cnt`.
  - Each `data_ok` with `discard_cnt != 0` decrements it and is otherwise ignored.
  - `ms_allowin` is forced 0 while `discard_cnt != 0`.
  - Requests still owned by execute at flush are execute's responsibility.
- **Forward.** `load_pending = ms_valid & |load_op & !ms_ready_go`. Decode must stall on a dest match while this is high.

## Timing
- **Reset values:** `ms_valid` 0, `ms_allowin` 1, `ms_to_ws_valid` 0, `buf_valid` 0, `discard_cnt` 0, `ms_forward` valid bits 0.
- **Latency:** minimum 1 cycle, when `data_ok` arrives in the cycle after capture. `data_ok` → `ms_ready_go` → `ms_to_ws_valid` is combinational.
- **No response loss:** `data_ok` in the same cycle as `ws_allowin=0` is buffered and not lost.
- **Simultaneous `wb_flush` and `data_ok`** for the current instruction: the response is consumed; there is no discard increment and no handoff.
- **Simultaneous flush and a new `es_to_ms_valid`:** the new instruction is dropped (`ms_valid` 0 next cycle).
- **Counter saturation:** `discard_cnt` saturates at max. This is an assertion, not functional behaviour.
- **Reset mid-wait:** all state clears. Outstanding responses are not tracked (the SRAM is reset too).

## Structure
- **Shared package (`mycpu.h`):**
  - `ES_TO_MS_BUS_WD`, `MS_TO_WS_BUS_WD`, `MS_FORWARD_WD`
  - `load_op` bit positions
  - `ECODE_*` constants
- **Sub-module `load_extract`:** combinational, with `load_op`, `addr_lo`, `rdata` in and a 32-bit result out.
- The rest of the stage is flat, with registers in `mem_stage`.

## Test plan
- **ALU op:** `mem_req=0`, `es_result=0x1234`, `ws_allowin=1` → `ms_to_ws_valid` the cycle after capture, `final_result=0x1234`.
- **ld.b:** `addr_lo=3`, `rdata=0x80FF_0011`, `data_ok` next cycle → `final_result=0xFFFF_FF80`. **ld.hu:** `addr_lo=2` → `0x0000_80FF`.
- **Delayed response:** `data_ok` 3 cycles late → `ms_allowin=0` and `load_pending=1` for 3 cycles, then a single handoff.
- **Buffered response:** `data_ok` with `ws_allowin=0` for 2 cycles, `rdata` changes afterwards → the buffered value is delivered.
- **Flush with request outstanding:** `discard_cnt` becomes 1. The next `data_ok` (`rdata=0xDEAD`) is dropped with no `ms_to_ws_valid`, and `ms_allowin` returns to 1 after it.
- **Exception pass-through:** `ms_ex=1`, `mem_req=1` → immediate handoff with ex/ecode preserved. A `data_ok` never arrives and is never awaited.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared bus layouts, load-op encoding and exception codes for the memory stage.
package mem_stage_pkg;

    // Execute-to-memory payload; the low 119 bits double as the writeback layout.
    typedef struct packed {
        logic [1:0]  addr_lo;
        logic [4:0]  load_op;
        logic        mem_req;
        logic [31:0] vaddr;
        logic [8:0]  esubcode;
        logic [5:0]  ecode;
        logic        ex;
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_t;

    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD = 119;
    localparam int MS_FORWARD_WD   = 42;

    localparam int LOAD_B  = 0;
    localparam int LOAD_H  = 1;
    localparam int LOAD_W  = 2;
    localparam int LOAD_BU = 3;
    localparam int LOAD_HU = 4;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;

endpackage

// File: rtl/mem_stage_load_extract.sv
// Selects the addressed byte/half of a load response and sign/zero-extends it.
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [4:0]  load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        if (load_op[LOAD_B])
            result = 32'(byte_sel);
        else if (load_op[LOAD_BU])
            result = {24'h0, byte_sel};
        else if (load_op[LOAD_H])
            result = 32'(half_sel);
        else if (load_op[LOAD_HU])
            result = {16'h0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data-SRAM response, extracts load data,
// and drops responses that belong to flushed instructions.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DISCARD_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       wb_flush,
    output logic [MS_FORWARD_WD-1:0]   ms_forward
);

    localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

    es_to_ms_t             ms_bus_p1;
    logic                  ms_valid;
    logic                  buf_valid;
    logic [31:0]           rdata_buf;
    logic [DISCARD_W-1:0]  discard_cnt;

    logic                  discard_busy;
    logic                  resp_ok;
    logic                  ms_ready_go;
    logic                  capture;
    logic                  leave;
    logic                  buf_load;
    logic                  discard_inc;
    logic                  discard_dec;
    logic                  load_pending;
    logic [31:0]           load_rdata;
    logic [31:0]           load_result;
    logic [31:0]           final_result;

    // A response only belongs to the current instruction once all stale ones are drained.
    assign discard_busy = (discard_cnt != '0);
    assign resp_ok      = data_sram_data_ok & ~discard_busy;

    assign ms_ready_go    = ~ms_bus_p1.mem_req | ms_bus_p1.ex | buf_valid | resp_ok;
    assign ms_allowin     = ~discard_busy & (~ms_valid | (ms_ready_go & ws_allowin));
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~wb_flush;

    assign capture  = es_to_ms_valid & ms_allowin;
    assign leave    = ms_valid & ms_ready_go & ws_allowin;
    assign buf_load = ms_valid & ms_bus_p1.mem_req & ~buf_valid & resp_ok;

    assign discard_inc = wb_flush & ms_valid & ms_bus_p1.mem_req & ~ms_bus_p1.ex
                       & ~buf_valid & ~data_sram_data_ok;
    assign discard_dec = data_sram_data_ok & discard_busy;

    // ---- stage register ----
    always_ff @(posedge clk) begin
        if (reset)
            ms_valid <= 1'b0;
        else if (wb_flush)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= es_to_ms_valid;
    end

    always_ff @(posedge clk) begin
        if (capture)
            ms_bus_p1 <= es_to_ms_t'(es_to_ms_bus);
    end

    // ---- response buffer and stale-response counter ----
    always_ff @(posedge clk) begin
        if (reset)
            buf_valid <= 1'b0;
        else if (capture | leave | wb_flush)
            buf_valid <= 1'b0;
        else if (buf_load)
            buf_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (buf_load)
            rdata_buf <= data_sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            discard_cnt <= '0;
        else if (discard_inc & ~discard_dec & ~(&discard_cnt))
            discard_cnt <= discard_cnt + DISCARD_ONE;
        else if (discard_dec & ~discard_inc)
            discard_cnt <= discard_cnt - DISCARD_ONE;
    end

    discard_cnt_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(discard_inc && !discard_dec && (&discard_cnt)));

    // ---- result formation ----
    assign load_rdata = buf_valid ? rdata_buf : data_sram_rdata;

    load_extract u_load_extract (
        .load_op (ms_bus_p1.load_op),
        .addr_lo (ms_bus_p1.addr_lo),
        .rdata   (load_rdata),
        .result  (load_result)
    );

    assign final_result = (|ms_bus_p1.load_op) ? load_result : ms_bus_p1.result;
    assign load_pending = ms_valid & (|ms_bus_p1.load_op) & ~ms_ready_go;

    assign ms_to_ws_bus = {ms_bus_p1.vaddr, ms_bus_p1.esubcode, ms_bus_p1.ecode,
                           ms_bus_p1.ex, ms_bus_p1.csr_re, ms_bus_p1.rf_we,
                           ms_bus_p1.dest, final_result, ms_bus_p1.pc};

    assign ms_forward = {ms_bus_p1.ex & ms_valid, ms_bus_p1.csr_re, load_pending,
                         ms_bus_p1.rf_we, ms_bus_p1.dest, final_result, ms_valid};

endmodule
